// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle fast path for divide special cases.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state;
    logic [2:0]          op_r;
    logic                neg_q;
    logic                neg_r;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   prod;

    logic                accept;
    logic                a_sgn;
    logic                b_sgn;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN-1:0]     fast_res;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_trial;
    logic [XLEN-1:0]     div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     fix_res;

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Request decode: operand signedness per op, magnitudes, special cases
    assign accept   = in_valid & in_ready & ~flush;
    assign a_sgn    = (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110) && a[XLEN-1];
    assign b_sgn    = (op == 3'b001 || op == 3'b100 || op == 3'b110) && b[XLEN-1];
    assign mag_a    = neg_if(a_sgn, a);
    assign mag_b    = neg_if(b_sgn, b);
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    assign fast_res = div_zero ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : a);

    // One iteration step; prod holds {acc/rem, multiplier/dividend}
    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    assign div_trial = prod[2*XLEN-1:XLEN-1];
    assign div_ge    = (div_trial >= {1'b0, opnd});
    assign div_diff  = div_trial[XLEN-1:0] - opnd;

    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        fix_res = '0;
        if (!op_r[2])
            fix_res = (op_r[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (!op_r[1])
            fix_res = neg_if(neg_q, prod[XLEN-1:0]);
        else
            fix_res = neg_if(neg_r, prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= op;
                        neg_q <= a_sgn ^ b_sgn;
                        neg_r <= a_sgn;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            state  <= DONE;
                            result <= fast_res;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state  <= IDLE;
                        result <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            opnd <= op[2] ? mag_b : mag_a;
            prod <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
        end else if (state == CALC) begin
            if (!op_r[2])
                prod <= {mul_sum, prod[XLEN-1:1]};
            else
                prod <= {(div_ge ? div_diff : div_trial[XLEN-1:0]), prod[XLEN-2:0], div_ge};
        end
    end
endmodule
